// File: rtl/reg_pkg.sv
// Shared definitions for the serial-in, parallel-out word collector.
//   DATA_W        default bits per word
//   hold_state_t  states of the output holding register
//   place_index   word bit position that receives the n-th serial bit
package reg_pkg;

  localparam int DATA_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_t;

  // Position of the bit accepted while cnt bits are already in the word.
  function automatic int unsigned place_index(input int unsigned cnt,
                                              input int unsigned width,
                                              input bit          lsb_first);
    if (lsb_first) begin
      return cnt;
    end else begin
      return width - 32'd1 - cnt;
    end
  endfunction

endpackage

// File: rtl/sipo_word_collector_if.sv
// Valid/ready word port of the SIPO word collector.
//   out_data   completed word, stable while out_valid=1
//   out_valid  holding register occupied
//   out_ready  consumer takes the word on an edge where out_valid=1
// master: collector side, slave: consumer side.
interface sipo_word_collector_if
  import reg_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit counter for the SIPO word collector.
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         synchronous return to 0, wins over en
//   en            count one accepted bit
//   cnt           bits accepted into the current partial word
//   wrap          this edge accepts the last bit of a word
module sipo_bit_counter
  import reg_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  logic [CW-1:0] cnt_r;
  logic          at_last_s;

  assign at_last_s = (cnt_r == CW'(WIDTH - 1));
  // Combinational so the holding register can load on the completing edge.
  assign wrap      = en && !clear && at_last_s;
  assign cnt       = cnt_r;

  // Counter state: clear, wrap at WIDTH-1, otherwise advance on enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      if (at_last_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sipo_word_collector.sv
// Serial-in, parallel-out word collector with a one-word holding register.
//   clk, reset_n  clock, asynchronous active-low reset
//   shift_en, sin serial bit and its qualifier
//   clear         drops the partial word and clears overrun
//   out_if        valid/ready word port (master side)
//   bit_cnt       bits accepted into the current partial word
//   overrun       sticky: a completed word found the holding register full
module sipo_word_collector
  import reg_pkg::*;
#(
  parameter  int WIDTH     = DATA_W,
  parameter  int LSB_FIRST = 1,
  localparam int CW        = $clog2(WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         shift_en,
  input  logic                         sin,
  input  logic                         clear,
  sipo_word_collector_if.master        out_if,
  output logic [CW-1:0]                bit_cnt,
  output logic                         overrun
);

  logic [CW-1:0]    cnt_s;
  logic             wrap_s;
  logic [CW-1:0]    idx_s;
  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] next_sreg_s;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             overrun_r;
  hold_state_t      state_r;

  sipo_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .en      (shift_en),
    .cnt     (cnt_s),
    .wrap    (wrap_s)
  );

  // Bit position for the incoming serial bit.
  always_comb begin
    idx_s = CW'(place_index(32'(cnt_s), WIDTH, LSB_FIRST != 0));
  end

  // Partial word with the current bit merged in; on a wrap this is the
  // complete word, so the holding register sees the last bit without delay.
  always_comb begin
    next_sreg_s        = sreg_r;
    next_sreg_s[idx_s] = sin;
  end

  // Partial-word shift register; emptied after a completed word or clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_r <= {WIDTH{1'b0}};
    end else if (clear || wrap_s) begin
      sreg_r <= {WIDTH{1'b0}};
    end else if (shift_en) begin
      sreg_r <= next_sreg_s;
    end else begin
      sreg_r <= sreg_r;
    end
  end

  // Holding-register FSM with the sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= EMPTY;
      valid_r   <= 1'b0;
      data_r    <= {WIDTH{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      // wrap_s is already suppressed by clear, so clear never drops a word.
      if (clear) begin
        overrun_r <= 1'b0;
      end else if (wrap_s && (state_r == FULL) && !out_if.out_ready) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      case (state_r)
        EMPTY: begin
          if (wrap_s) begin
            state_r <= FULL;
            valid_r <= 1'b1;
            data_r  <= next_sreg_s;
          end else begin
            state_r <= EMPTY;
            valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (out_if.out_ready) begin
            if (wrap_s) begin
              // Old word leaves as the new one arrives: stay FULL.
              data_r <= next_sreg_s;
            end else begin
              state_r <= EMPTY;
              valid_r <= 1'b0;
            end
          end else begin
            // Word held; any completion here is dropped (overrun above).
            state_r <= FULL;
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= EMPTY;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_data  = data_r;
  assign out_if.out_valid = valid_r;
  assign bit_cnt          = cnt_s;
  assign overrun          = overrun_r;

endmodule

// File: tb/tb_sipo_word_collector.sv
// Self-checking bench for sipo_word_collector (WIDTH=4). Two instances share
// the stimulus: one LSB-first, one MSB-first. Delivered words are checked
// against scoreboard queues; per-cycle state is checked from a vector table
// and from hand-written corner-case sequences.
module tb_sipo_word_collector;

  logic       clk;
  logic       reset_n;
  logic       shift_en;
  logic       sin;
  logic       clear;
  logic       out_ready;
  logic [1:0] bit_cnt_l;
  logic [1:0] bit_cnt_m;
  logic       overrun_l;
  logic       overrun_m;

  int n_checks;
  int n_fail;

  logic [3:0] sb_l[$];
  logic [3:0] sb_m[$];

  sipo_word_collector_if #(.WIDTH(4)) bus_l ();
  sipo_word_collector_if #(.WIDTH(4)) bus_m ();

  assign bus_l.out_ready = out_ready;
  assign bus_m.out_ready = out_ready;

  sipo_word_collector #(.WIDTH(4), .LSB_FIRST(1)) dut_l (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (shift_en),
    .sin      (sin),
    .clear    (clear),
    .out_if   (bus_l.master),
    .bit_cnt  (bit_cnt_l),
    .overrun  (overrun_l)
  );

  sipo_word_collector #(.WIDTH(4), .LSB_FIRST(0)) dut_m (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (shift_en),
    .sin      (sin),
    .clear    (clear),
    .out_if   (bus_m.master),
    .bit_cnt  (bit_cnt_m),
    .overrun  (overrun_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       se;
    logic       sin;
    logic       clr;
    logic       rdy;
    logic       push;
    logic [3:0] exp_data;
    logic       exp_valid;
    logic [1:0] exp_cnt;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic se, input logic s, input logic clr,
                              input logic rdy, input logic push,
                              input logic [3:0] d, input logic v,
                              input logic [1:0] c, input logic o);
    vec_t r;
    r.se = se; r.sin = s; r.clr = clr; r.rdy = rdy; r.push = push;
    r.exp_data = d; r.exp_valid = v; r.exp_cnt = c; r.exp_ovr = o;
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] w);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [3:0] w);
    sb_l.push_back(w);
    sb_m.push_back(rev4(w));
  endtask

  // Checks any transfer happening on the coming edge, then advances a cycle.
  task automatic tick();
    logic [3:0] e;
    if (bus_l.out_valid && out_ready) begin
      if (sb_l.size() == 0) begin
        chk("sb_lsb_unexpected_word", 32'(bus_l.out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb_l.pop_front();
        chk("sb_lsb_word", 32'(bus_l.out_data), 32'(e));
      end
    end
    if (bus_m.out_valid && out_ready) begin
      if (sb_m.size() == 0) begin
        chk("sb_msb_unexpected_word", 32'(bus_m.out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb_m.pop_front();
        chk("sb_msb_word", 32'(bus_m.out_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Sends w bit 0 first; rdy applies to all but the last bit's edge.
  task automatic send_word(input logic [3:0] w, input logic rdy, input logic rdy_last,
                           input int gap, input bit push);
    for (int i = 0; i < 4; i++) begin
      shift_en  = 1'b1;
      sin       = w[i];
      out_ready = (i == 3) ? rdy_last : rdy;
      if (i == 3 && push) push_word(w);
      tick();
      shift_en = 1'b0;
      sin      = 1'b0;
      if (i < 3 && gap > 0) begin
        out_ready = rdy;
        repeat (gap) tick();
        chk("gap_hold_cnt", 32'(bit_cnt_l), 32'(i + 1));
      end
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] d, input logic v,
                           input logic [1:0] c, input logic o);
    chk({tag, "_data_lsb"}, 32'(bus_l.out_data), 32'(d));
    chk({tag, "_data_msb"}, 32'(bus_m.out_data), 32'(rev4(d)));
    chk({tag, "_valid"}, 32'(bus_l.out_valid), 32'(v));
    chk({tag, "_valid_msb"}, 32'(bus_m.out_valid), 32'(v));
    chk({tag, "_cnt"}, 32'(bit_cnt_l), 32'(c));
    chk({tag, "_ovr"}, 32'(overrun_l), 32'(o));
    chk({tag, "_ovr_msb"}, 32'(overrun_m), 32'(o));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    shift_en = 1'b0;
    sin      = 1'b0;
    clear    = 1'b0;
    out_ready = 1'b0;

    // Words 4'hB (case 2), then 4'hA and 4'h5 back to back (case 3).
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 2'd1, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 2'd2, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 2'd3, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hB, 1'b1, 2'd0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 2'd0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 2'd1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 2'd2, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 2'd3, 1'b0);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 2'd0, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 2'd1, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 2'd2, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 2'd3, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 2'd0, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 2'd0, 1'b0);

    // Reset state.
    #3;
    chk_state("reset", 4'h0, 1'b0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Case 1: reset mid-frame acts without a clock edge.
    shift_en = 1'b1;
    sin      = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("pre_reset_cnt", 32'(bit_cnt_l), 32'd2);
    shift_en = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk_state("async_reset", 4'h0, 1'b0, 2'd0, 1'b0);
    #2;
    reset_n = 1'b1;
    send_word(4'h9, 1'b1, 1'b1, 0, 1'b1);
    chk_state("fresh_word", 4'h9, 1'b1, 2'd0, 1'b0);

    // Cases 2 and 3 from the vector table.
    for (int i = 0; i < 14; i++) begin
      shift_en  = vecs[i].se;
      sin       = vecs[i].sin;
      clear     = vecs[i].clr;
      out_ready = vecs[i].rdy;
      if (vecs[i].push) push_word(vecs[i].exp_data);
      tick();
      chk($sformatf("vec%0d_data_lsb", i), 32'(bus_l.out_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_data_msb", i), 32'(bus_m.out_data), 32'(rev4(vecs[i].exp_data)));
      chk($sformatf("vec%0d_valid", i), 32'(bus_l.out_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_cnt", i), 32'(bit_cnt_l), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_ovr", i), 32'(overrun_l), 32'(vecs[i].exp_ovr));
    end
    shift_en = 1'b0;

    // Case 5: transfer and completion on the same edge.
    send_word(4'h3, 1'b0, 1'b0, 0, 1'b1);
    chk_state("simul_first", 4'h3, 1'b1, 2'd0, 1'b0);
    send_word(4'h6, 1'b0, 1'b1, 0, 1'b1);
    chk_state("simul_load", 4'h6, 1'b1, 2'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("simul_drain_valid", 32'(bus_l.out_valid), 32'd0);

    // Case 4: backpressure, dropped word, sticky overrun, clear.
    send_word(4'h3, 1'b0, 1'b0, 0, 1'b1);
    chk_state("bp_first", 4'h3, 1'b1, 2'd0, 1'b0);
    send_word(4'hC, 1'b0, 1'b0, 0, 1'b0);
    chk_state("bp_drop", 4'h3, 1'b1, 2'd0, 1'b1);
    tick();
    chk_state("bp_sticky", 4'h3, 1'b1, 2'd0, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_state("bp_clear", 4'h3, 1'b1, 2'd0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain_valid", 32'(bus_l.out_valid), 32'd0);

    // Case 6: gaps between bits, clear after a partial word, MSB-first check.
    send_word(4'h7, 1'b1, 1'b1, 3, 1'b1);
    chk_state("gap_word", 4'h7, 1'b1, 2'd0, 1'b0);
    tick();
    shift_en = 1'b1;
    sin      = 1'b1;
    tick();
    sin = 1'b0;
    tick();
    chk("partial_cnt", 32'(bit_cnt_l), 32'd2);
    clear = 1'b1;
    sin   = 1'b1;
    tick();
    clear    = 1'b0;
    shift_en = 1'b0;
    chk_state("clear_prio", 4'h7, 1'b0, 2'd0, 1'b0);
    send_word(4'h2, 1'b1, 1'b1, 0, 1'b1);
    chk_state("after_clear", 4'h2, 1'b1, 2'd0, 1'b0);
    tick();
    send_word(4'b1011, 1'b1, 1'b1, 0, 1'b1);
    chk("msb_first_word", 32'(bus_m.out_data), 32'(4'b1101));
    chk("lsb_first_word", 32'(bus_l.out_data), 32'(4'b1011));
    tick();
    out_ready = 1'b0;
    tick();

    chk("sb_lsb_empty", 32'(sb_l.size()), 32'd0);
    chk("sb_msb_empty", 32'(sb_m.size()), 32'd0);
    chk_state("final", 4'hB, 1'b0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
